// File: rtl/dmem_minmax_scan_if.sv
// Data-memory bus between the min/max scanner (master) and the single-port data memory (slave).
// Read data is valid the cycle after a cycle with mem_read=1.
interface dmem_minmax_scan_if #(
  parameter int WIDTH = 32
);
  logic             mem_read;
  logic             mem_write;
  logic [WIDTH-1:0] read_address;
  logic [WIDTH-1:0] write_address;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] mem_data;

  modport master (
    output mem_read, mem_write, read_address, write_address, write_data,
    input  mem_data
  );

  modport slave (
    input  mem_read, mem_write, read_address, write_address, write_data,
    output mem_data
  );
endinterface

// File: rtl/dmem_minmax_scan.sv
// Scans a block of data memory for its max/min and writes both to fixed result words.
// Define SCAN_UNSIGNED_EN for unsigned comparisons (default is signed two's complement).
module dmem_minmax_scan #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 10,
  parameter int MAX_ADDR = 1022,
  parameter int MIN_ADDR = 1023
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     count,
  dmem_minmax_scan_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    max_val,
  output logic [WIDTH-1:0]    min_val
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    DRAIN  = 3'd2,
    WR_MAX = 3'd3,
    WR_MIN = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [ADDR_W:0]    cnt_q, cnt_d;
  logic [ADDR_W:0]    idx_q, idx_d;
  logic               first_q, first_d;
  logic               rd_pend_q, rd_pend_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]   wr_data_q, wr_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   max_q, max_d;
  logic [WIDTH-1:0]   min_q, min_d;

  logic sample_gt_max;
  logic sample_lt_min;

`ifdef SCAN_UNSIGNED_EN
  assign sample_gt_max = bus.mem_data > max_q;
  assign sample_lt_min = bus.mem_data < min_q;
`else
  assign sample_gt_max = $signed(bus.mem_data) > $signed(max_q);
  assign sample_lt_min = $signed(bus.mem_data) < $signed(min_q);
`endif

  // Sample capture: runs independently of the FSM so DRAIN consumes the last read.
  always_comb begin
    max_d   = max_q;
    min_d   = min_q;
    first_d = first_q;
    if (rd_pend_q) begin
      first_d = 1'b0;
      if (first_q) begin
        max_d = bus.mem_data;
        min_d = bus.mem_data;
      end else begin
        if (sample_gt_max) max_d = bus.mem_data;
        if (sample_lt_min) min_d = bus.mem_data;
      end
    end
    if (state_q == IDLE && start && count != '0) begin
      first_d = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rd_pend_d   = mem_read_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    rd_addr_d   = '0;
    wr_addr_d   = '0;
    wr_data_d   = '0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            base_d     = base_addr;
            cnt_d      = count;
            idx_d      = {{ADDR_W{1'b0}}, 1'b1};
            mem_read_d = 1'b1;
            rd_addr_d  = base_addr;
            busy_d     = 1'b1;
            state_d    = READ;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      // idx_q counts addresses already issued; the first was issued leaving IDLE.
      READ: begin
        busy_d = 1'b1;
        if (idx_q == cnt_q) begin
          state_d = DRAIN;
        end else begin
          mem_read_d = 1'b1;
          rd_addr_d  = base_q + idx_q[ADDR_W-1:0];
          idx_d      = idx_q + 1'b1;
        end
      end
      DRAIN: begin
        busy_d      = 1'b1;
        mem_write_d = 1'b1;
        wr_addr_d   = ADDR_W'(MAX_ADDR);
        wr_data_d   = max_d;
        state_d     = WR_MAX;
      end
      WR_MAX: begin
        busy_d      = 1'b1;
        mem_write_d = 1'b1;
        wr_addr_d   = ADDR_W'(MIN_ADDR);
        wr_data_d   = min_q;
        state_d     = WR_MIN;
      end
      WR_MIN: begin
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      first_q     <= 1'b0;
      rd_pend_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      max_q       <= '0;
      min_q       <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      first_q     <= first_d;
      rd_pend_q   <= rd_pend_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      max_q       <= max_d;
      min_q       <= min_d;
    end
  end

  assign bus.mem_read      = mem_read_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.read_address  = {{(WIDTH-ADDR_W){1'b0}}, rd_addr_q};
  assign bus.write_address = {{(WIDTH-ADDR_W){1'b0}}, wr_addr_q};
  assign bus.write_data    = wr_data_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign max_val           = max_q;
  assign min_val           = min_q;

endmodule

// File: tb/tb_dmem_minmax_scan.sv
// Bench for dmem_minmax_scan: behavioural memory plus a scoreboard of expected
// read/write accesses (with their cycle numbers) built from the memory contents.
module tb_dmem_minmax_scan;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   count = '0;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  max_val;
  logic [WIDTH-1:0]  min_val;

  dmem_minmax_scan_if #(.WIDTH(WIDTH)) bus ();

  dmem_minmax_scan #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .MAX_ADDR(1022), .MIN_ADDR(1023)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .bus(bus), .busy(busy), .done(done), .max_val(max_val), .min_val(min_val)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] mem [DEPTH];

  always @(posedge clk) begin
    if (bus.mem_read) bus.mem_data <= mem[bus.read_address[ADDR_W-1:0]];
    if (bus.mem_write) mem[bus.write_address[ADDR_W-1:0]] <= bus.write_data;
  end

  typedef struct {
    int               cyc;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] data;
  } acc_t;

  acc_t rd_q[$];
  acc_t wr_q[$];
  int   tests_run = 0;
  int   failures  = 0;
  logic [WIDTH-1:0] exp_max = '0;
  logic [WIDTH-1:0] exp_min = '0;

  function automatic bit is_greater(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef SCAN_UNSIGNED_EN
    return a > b;
`else
    return $signed(a) > $signed(b);
`endif
  endfunction

  // Pre-compute the expected accesses and results from the pre-scan memory image.
  task automatic applyStimulus(input logic [ADDR_W-1:0] base, input int n);
    logic [WIDTH-1:0] mx, mn, d;
    int a;
    mx = '0;
    mn = '0;
    if (n == 0) return;
    for (int k = 0; k < n; k++) begin
      a = (int'(base) + k) % DEPTH;
      d = mem[a];
      rd_q.push_back('{k + 1, WIDTH'(a), '0});
      if (k == 0) begin
        mx = d;
        mn = d;
      end else begin
        if (is_greater(d, mx)) mx = d;
        if (is_greater(mn, d)) mn = d;
      end
    end
    exp_max = mx;
    exp_min = mn;
    wr_q.push_back('{n + 2, 32'd1022, mx});
    wr_q.push_back('{n + 3, 32'd1023, mn});
  endtask

  // Starts one scan and scores every cycle up to one past the done pulse.
  task automatic run_scan(input logic [ADDR_W-1:0] base, input int n, input string name);
    int   done_cyc;
    acc_t e;
    logic exp_busy;
    done_cyc = (n == 0) ? 1 : n + 4;
    @(negedge clk);
    base_addr = base;
    count     = n[ADDR_W:0];
    start     = 1'b1;
    applyStimulus(base, n);
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= done_cyc + 1; cyc++) begin
      @(negedge clk);
      tests_run++;
      if (bus.mem_read && bus.mem_write) begin
        failures++;
        $display("[TB] FAIL %s both_strobes cyc %0d: got read=1 write=1, expected at most one", name, cyc);
      end
      if (bus.mem_read) begin
        tests_run++;
        if (rd_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL %s extra_read cyc %0d: got read of %0h, expected none", name, cyc, bus.read_address);
        end else begin
          e = rd_q.pop_front();
          if (bus.read_address !== e.addr || cyc != e.cyc) begin
            failures++;
            $display("[TB] FAIL %s read cyc %0d: got addr %0h, expected addr %0h in cyc %0d",
                     name, cyc, bus.read_address, e.addr, e.cyc);
          end
        end
      end
      if (bus.mem_write) begin
        tests_run++;
        if (wr_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL %s extra_write cyc %0d: got write to %0h, expected none", name, cyc, bus.write_address);
        end else begin
          e = wr_q.pop_front();
          if (bus.write_address !== e.addr || bus.write_data !== e.data || cyc != e.cyc) begin
            failures++;
            $display("[TB] FAIL %s write cyc %0d: got %0h<=%0h, expected %0h<=%0h in cyc %0d",
                     name, cyc, bus.write_address, bus.write_data, e.addr, e.data, e.cyc);
          end
        end
      end
      exp_busy = (n != 0) && (cyc <= n + 3);
      tests_run++;
      if (busy !== exp_busy || done !== (cyc == done_cyc)) begin
        failures++;
        $display("[TB] FAIL %s busy_done cyc %0d: got busy=%b done=%b, expected busy=%b done=%b",
                 name, cyc, busy, done, exp_busy, (cyc == done_cyc));
      end
    end
    tests_run++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s missing_access: got %0d reads %0d writes outstanding, expected 0 0",
               name, rd_q.size(), wr_q.size());
      rd_q.delete();
      wr_q.delete();
    end
    tests_run++;
    if (max_val !== exp_max || min_val !== exp_min) begin
      failures++;
      $display("[TB] FAIL %s result: got max=%0h min=%0h, expected max=%0h min=%0h",
               name, max_val, min_val, exp_max, exp_min);
    end
  endtask

  task automatic checkOutput(input string name);
    tests_run++;
    if ({bus.mem_read, bus.mem_write, busy, done} !== 4'b0 ||
        bus.read_address !== '0 || bus.write_address !== '0 || bus.write_data !== '0 ||
        max_val !== '0 || min_val !== '0) begin
      failures++;
      $display("[TB] FAIL %s reset_outputs: got rd=%b wr=%b busy=%b done=%b ra=%0h wa=%0h wd=%0h max=%0h min=%0h, expected all 0",
               name, bus.mem_read, bus.mem_write, busy, done, bus.read_address,
               bus.write_address, bus.write_data, max_val, min_val);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset");
    reset = 1'b1;
    @(negedge clk);
    checkOutput("after_release");
  endtask

  task automatic test_basic();
    mem[100] = 32'd5;
    mem[101] = 32'hFFFF_FFFD;
    mem[102] = 32'd17;
    mem[103] = 32'd0;
    run_scan(10'd100, 4, "basic");
`ifdef SCAN_UNSIGNED_EN
    tests_run++;
    if (max_val !== 32'hFFFF_FFFD || min_val !== 32'd0) begin
      failures++;
      $display("[TB] FAIL basic_const: got max=%0h min=%0h, expected fffffffd 0", max_val, min_val);
    end
`else
    tests_run++;
    if (max_val !== 32'd17 || min_val !== 32'hFFFF_FFFD) begin
      failures++;
      $display("[TB] FAIL basic_const: got max=%0h min=%0h, expected 11 fffffffd", max_val, min_val);
    end
`endif
  endtask

  task automatic test_single();
    mem[200] = 32'd42;
    run_scan(10'd200, 1, "single");
  endtask

  task automatic test_zero_count();
    run_scan(10'd300, 0, "zero_count");
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 4; k++) mem[k] = $urandom;
    mem[1020] = 32'd7;
    mem[1021] = 32'd9;
    mem[1022] = 32'h7FFF_FFFF;
    mem[1023] = 32'h8000_0000;
    run_scan(10'd1020, 8, "wrap");
  endtask

  task automatic test_full();
    run_scan(10'd5, DEPTH, "full");
  endtask

  task automatic test_back_to_back();
    for (int k = 500; k < 506; k++) mem[k] = $urandom;
    run_scan(10'd500, 6, "b2b_first");
    run_scan(10'd503, 3, "b2b_second");
  endtask

  task automatic test_reset_mid_scan();
    for (int k = 600; k < 610; k++) mem[k] = $urandom;
    @(negedge clk);
    base_addr = 10'd600;
    count     = 11'd10;
    start     = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 2; cyc++) begin
      @(negedge clk);
      tests_run++;
      if (bus.mem_read !== 1'b1 || bus.read_address !== 32'(600 + cyc - 1)) begin
        failures++;
        $display("[TB] FAIL held_start cyc %0d: got rd=%b addr=%0h, expected rd=1 addr=%0h",
                 cyc, bus.mem_read, bus.read_address, 600 + cyc - 1);
      end
    end
    @(posedge clk);
    #2 reset = 1'b0;
    #1 checkOutput("mid_scan_reset");
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    exp_max = '0;
    exp_min = '0;
    run_scan(10'd600, 10, "after_mid_reset");
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) mem[k] = $urandom;
    test_reset();
    test_basic();
    test_single();
    test_zero_count();
    test_wrap();
    test_full();
    test_back_to_back();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
